// File: rtl/cpu_pkg.sv
// Shared CPU types and constants: PC width, reset PC, IFU state encoding and
// instruction field positions.
package cpu_pkg;

  localparam int unsigned PC_W   = 30;
  localparam int unsigned XLEN   = 32;
  localparam int unsigned IMM_W  = 16;
  localparam int unsigned JIDX_W = 26;
  localparam int unsigned CNT_W  = 8;

  // Word address of 0x0000_3000
  localparam logic [PC_W-1:0] DEF_RESET_PC = 30'h0000_0C00;

  // Instruction field slices
  localparam int unsigned IMM16_MSB  = 15;
  localparam int unsigned IMM16_LSB  = 0;
  localparam int unsigned JIDX26_MSB = 25;
  localparam int unsigned JIDX26_LSB = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    ERR   = 2'd3
  } ifu_state_t;

endpackage

// File: rtl/ifu_if.sv
// Fetch-side bus: instruction memory req/ack and the decode valid/ready handshake.
interface ifu_if
  import cpu_pkg::*;
();

  logic              imem_req;
  logic [PC_W-1:0]   imem_addr;
  logic              imem_ack;
  logic [XLEN-1:0]   imem_rdata;
  logic [XLEN-1:0]   instr;
  logic              instr_valid;
  logic              instr_ready;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata,
    output instr,
    output instr_valid,
    input  instr_ready
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata,
    input  instr,
    input  instr_valid,
    output instr_ready
  );

endinterface

// File: rtl/ifu_target.sv
// Branch and jump target computation from the current PC and instruction.
module ifu_target
  import cpu_pkg::*;
(
  input  logic [PC_W-1:0]   pc,
  input  logic [JIDX_W-1:0] instr_lo,
  output logic [PC_W-1:0]   br_target,
  output logic [JIDX_W-1:0] j_target
);

  logic [IMM_W-1:0] imm;

  assign imm = instr_lo[IMM16_MSB:IMM16_LSB];

  // Sign-extended word offset; wraps modulo 2^30
  assign br_target = pc + PC_W'(1) + {{(PC_W - IMM_W){imm[IMM_W-1]}}, imm};
  assign j_target  = instr_lo[JIDX26_MSB:JIDX26_LSB];

endmodule

// File: rtl/ifu.sv
// Instruction fetch unit: PC register, fetch FSM with memory timeout, and the
// decode-side valid/ready handshake.
module ifu
  import cpu_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = DEF_RESET_PC,
  parameter int unsigned     MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PC_W-1:0]   npc,
  ifu_if.master             bus,
  output logic [PC_W-1:0]   pc,
  output logic [JIDX_W-1:0] j_target,
  output logic [PC_W-1:0]   br_target,
  output logic              fetch_err
);

  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(MAX_WAIT - 1);

  ifu_state_t       state, state_nxt;
  logic [PC_W-1:0]  pc_q, pc_nxt;
  logic [XLEN-1:0]  instr_q, instr_nxt;
  logic [CNT_W-1:0] wait_cnt, wait_nxt;
  logic             req, valid, err;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      pc_q     <= RESET_PC;
      instr_q  <= '0;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      pc_q     <= pc_nxt;
      instr_q  <= instr_nxt;
      wait_cnt <= wait_nxt;
    end
  end

  // Next state; handshake outputs depend on state only
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc_q;
    instr_nxt = instr_q;
    wait_nxt  = wait_cnt;
    req       = 1'b0;
    valid     = 1'b0;
    err       = 1'b0;
    unique case (state)
      IDLE: state_nxt = FETCH;
      FETCH: begin
        req = 1'b1;
        if (bus.imem_ack) begin
          instr_nxt = bus.imem_rdata;
          wait_nxt  = '0;
          state_nxt = HOLD;
        end else if (wait_cnt == LAST_WAIT) begin
          state_nxt = ERR;
        end else begin
          wait_nxt = wait_cnt + CNT_W'(1);
        end
      end
      HOLD: begin
        valid = 1'b1;
        if (bus.instr_ready) begin
          pc_nxt    = npc;
          state_nxt = FETCH;
        end
      end
      ERR: err = 1'b1;
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.imem_req    = req;
  assign bus.imem_addr   = pc_q;
  assign bus.instr       = instr_q;
  assign bus.instr_valid = valid;
  assign fetch_err       = err;
  assign pc              = pc_q;

  ifu_target u_target (
    .pc        (pc_q),
    .instr_lo  (instr_q[JIDX_W-1:0]),
    .br_target (br_target),
    .j_target  (j_target)
  );

endmodule
